lsu_wb: RTL

- Load/store and writeback stage sitting directly upstream of the integer register file in the RV64 core.
- Accepts one EX-stage operation at a time and computes the effective address.
- Runs a req/gnt/rvalid handshake with a 64-bit data memory port, with byte-lane masking, then sign/zero-extends load data.
- Drives the register file's write port (reg_wen/reg_waddr/reg_wdata); non-memory ops pass their result straight to writeback.

---
 rtl/lsu_wb_pkg.sv | 19 +
 rtl/lsu_lane_align.sv | 44 ++++
 rtl/lsu_wb.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/lsu_wb_pkg.sv
// Shared types and constants for the load/store writeback stage and its lane aligner.
package lsu_wb_pkg;

    localparam int CPU_WIDTH      = 64;
    localparam int REG_ADDR_WIDTH = 5;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_WB
    } state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for a 64-bit memory word: store mask/data placement,
// load extraction with sign/zero extension, and natural-alignment check.
module lsu_lane_align
    import lsu_wb_pkg::*;
(
    input  logic [2:0]           off_i,
    input  logic [1:0]           size_i,
    input  logic                 unsigned_i,
    input  logic [CPU_WIDTH-1:0] st_data_i,
    input  logic [CPU_WIDTH-1:0] ld_data_i,
    output logic [7:0]           wmask_o,
    output logic [CPU_WIDTH-1:0] wdata_o,
    output logic [CPU_WIDTH-1:0] ld_data_o,
    output logic                 misalign_o
);

    logic [3:0]           nbytes;
    logic [7:0]           lanes;
    logic [CPU_WIDTH-1:0] raw;

    always_comb begin
        nbytes     = 4'd1 << size_i;
        misalign_o = (({1'b0, off_i}) & (nbytes - 4'd1)) != 4'd0;

        case (size_i)
            SZ_B:    lanes = 8'h01;
            SZ_H:    lanes = 8'h03;
            SZ_W:    lanes = 8'h0F;
            default: lanes = 8'hFF;
        endcase
        wmask_o = lanes << off_i;
        wdata_o = st_data_i << {off_i, 3'b000};

        raw       = ld_data_i >> {off_i, 3'b000};
        ld_data_o = raw;
        case (size_i)
            SZ_B:    ld_data_o = unsigned_i ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
            SZ_H:    ld_data_o = unsigned_i ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
            SZ_W:    ld_data_o = unsigned_i ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
            default: ld_data_o = raw;
        endcase
    end

endmodule

// File: rtl/lsu_wb.sv
// Load/store + writeback stage: one op in flight, req/gnt/rvalid memory port,
// results delivered to the integer register file write port.
module lsu_wb #(
    parameter int CPU_WIDTH      = 64,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ADDR_WIDTH     = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ex_valid,
    output logic                      ex_ready,
    input  logic                      ex_is_load,
    input  logic                      ex_is_store,
    input  logic [1:0]                ex_size,
    input  logic                      ex_unsigned,
    input  logic [CPU_WIDTH-1:0]      ex_base,
    input  logic [31:0]               ex_imm,
    input  logic [CPU_WIDTH-1:0]      ex_wdata,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [CPU_WIDTH-1:0]      mem_wdata,
    output logic [7:0]                mem_wmask,
    input  logic                      mem_gnt,
    input  logic                      mem_rvalid,
    input  logic [CPU_WIDTH-1:0]      mem_rdata,
    output logic                      reg_wen,
    output logic [REG_ADDR_WIDTH-1:0] reg_waddr,
    output logic [CPU_WIDTH-1:0]      reg_wdata,
    output logic                      misalign,
    output logic                      busy
);
    import lsu_wb_pkg::*;

    state_t                    state_q, state_d;
    logic                      mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]     mem_addr_q, mem_addr_d;
    logic [CPU_WIDTH-1:0]      mem_wdata_q, mem_wdata_d;
    logic [7:0]                mem_wmask_q, mem_wmask_d;
    logic                      reg_wen_q, reg_wen_d;
    logic [REG_ADDR_WIDTH-1:0] reg_waddr_q, reg_waddr_d;
    logic [CPU_WIDTH-1:0]      reg_wdata_q, reg_wdata_d;
    logic                      misalign_q, misalign_d, busy_q, busy_d;
    logic [2:0]                off_q, off_d;
    logic [1:0]                size_q, size_d;
    logic                      uns_q, uns_d;

    logic [ADDR_WIDTH-1:0]     eaddr;
    logic [2:0]                al_off;
    logic [1:0]                al_size;
    logic [7:0]                al_wmask;
    logic [CPU_WIDTH-1:0]      al_wdata, al_ld;
    logic                      al_misalign;
    logic                      is_mem;

    assign eaddr  = ADDR_WIDTH'(ex_base) + {{(ADDR_WIDTH-32){ex_imm[31]}}, ex_imm};
    assign is_mem = ex_is_load | ex_is_store;

    // The aligner serves the incoming op in IDLE and the captured load afterwards.
    assign al_off  = (state_q == S_IDLE) ? eaddr[2:0] : off_q;
    assign al_size = (state_q == S_IDLE) ? ex_size    : size_q;

    lsu_lane_align u_align (
        .off_i      (al_off),
        .size_i     (al_size),
        .unsigned_i (uns_q),
        .st_data_i  (ex_wdata),
        .ld_data_i  (mem_rdata),
        .wmask_o    (al_wmask),
        .wdata_o    (al_wdata),
        .ld_data_o  (al_ld),
        .misalign_o (al_misalign)
    );

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wmask_d = mem_wmask_q;
        reg_wen_d   = 1'b0;
        reg_waddr_d = reg_waddr_q;
        reg_wdata_d = reg_wdata_q;
        misalign_d  = 1'b0;
        off_d       = off_q;
        size_d      = size_q;
        uns_d       = uns_q;

        case (state_q)
            S_IDLE: if (ex_valid) begin
                if (is_mem && al_misalign) begin
                    misalign_d = 1'b1;
                end else if (is_mem) begin
                    mem_req_d   = 1'b1;
                    mem_addr_d  = {eaddr[ADDR_WIDTH-1:3], 3'b000};
                    off_d       = eaddr[2:0];
                    size_d      = ex_size;
                    uns_d       = ex_unsigned;
                    reg_waddr_d = ex_rd;
                    mem_we_d    = ex_is_store;
                    mem_wmask_d = ex_is_store ? al_wmask : 8'h00;
                    mem_wdata_d = ex_is_store ? al_wdata : mem_wdata_q;
                    state_d     = S_REQ;
                end else begin
                    reg_wdata_d = ex_base;
                    reg_waddr_d = ex_rd;
                    reg_wen_d   = (ex_rd != '0);
                    state_d     = S_WB;
                end
            end
            S_REQ: if (mem_gnt) begin
                mem_req_d = 1'b0;
                state_d   = mem_we_q ? S_IDLE : S_WAIT;
            end
            S_WAIT: if (mem_rvalid) begin
                reg_wdata_d = al_ld;
                reg_wen_d   = (reg_waddr_q != '0);
                state_d     = S_WB;
            end
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            reg_wen_q   <= 1'b0;
            reg_waddr_q <= '0;
            reg_wdata_q <= '0;
            misalign_q  <= 1'b0;
            busy_q      <= 1'b0;
            off_q       <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wmask_q <= mem_wmask_d;
            reg_wen_q   <= reg_wen_d;
            reg_waddr_q <= reg_waddr_d;
            reg_wdata_q <= reg_wdata_d;
            misalign_q  <= misalign_d;
            busy_q      <= busy_d;
            off_q       <= off_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
        end
    end

    assign ex_ready  = (state_q == S_IDLE) && !rst;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wmask = mem_wmask_q;
    assign reg_wen   = reg_wen_q;
    assign reg_waddr = reg_waddr_q;
    assign reg_wdata = reg_wdata_q;
    assign misalign  = misalign_q;
    assign busy      = busy_q;

endmodule
